// File: rtl/freq_meter_hertz_pkg.sv
// Shared constants and helpers for the Hertz-domain blocks (dividers and meters).
package freq_meter_hertz_pkg;

  // Board system clock, shared with the Hertz-rate clock dividers.
  localparam int unsigned CLK_FREQ_HZ = 12_000_000;

  // Gate window length in system clock cycles.
  function automatic int unsigned calcWindow(input int unsigned clkFreq,
                                             input int unsigned gateHz);
    return clkFreq / gateHz;
  endfunction

  // True when the gate rate yields a whole number of clock cycles per window.
  function automatic bit gateDividesClock(input int unsigned clkFreq,
                                          input int unsigned gateHz);
    return (gateHz != 0) && ((clkFreq % gateHz) == 0);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// Reusable for buttons and any other asynchronous input.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise_pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise_q;
  logic rise_d;

  assign rise_d = sync2_q & ~prev_q;

  // Resynchronize the input, remember its previous level and register the rising-edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= rise_d;
    end
  end

  assign sync_out   = sync2_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/freq_meter_hertz.sv
// Gated frequency meter: counts rising edges of sig_in over a fixed window
// and publishes the scaled result in Hertz with a one-cycle valid strobe.
module freq_meter_hertz
  import freq_meter_hertz_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = CLK_FREQ_HZ,
  parameter int unsigned GATE_HZ      = 1,
  parameter int unsigned COUNT_WIDTH  = 32,
  parameter int unsigned LOST_WINDOWS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   sig_in,
  output logic [COUNT_WIDTH-1:0] freq_hz,
  output logic                   meas_valid,
  output logic                   overflow,
  output logic                   signal_lost
);

  localparam int unsigned WIN    = calcWindow(CLK_FREQ, GATE_HZ);
  localparam int unsigned GATE_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned LOST_W = $clog2(LOST_WINDOWS + 1);
  localparam int unsigned PROD_W = COUNT_WIDTH + 32;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;
  localparam logic [GATE_W-1:0]      GATE_LAST  = GATE_W'(WIN - 1);
  localparam logic [LOST_W-1:0]      LOST_LIMIT = LOST_W'(LOST_WINDOWS);
  localparam logic [PROD_W-1:0]      GATE_MULT  = PROD_W'(GATE_HZ);

  if (!gateDividesClock(CLK_FREQ, GATE_HZ)) begin : gBadGate
    $error("freq_meter_hertz: GATE_HZ must divide CLK_FREQ exactly");
  end

  logic                   edgeDet;
  logic                   unusedSyncLevel;

  logic [GATE_W-1:0]      gateCnt_q,    gateCnt_d;
  logic [COUNT_WIDTH-1:0] edgeCnt_q,    edgeCnt_d;
  logic                   ovfPending_q, ovfPending_d;
  logic [LOST_W-1:0]      lostCnt_q,    lostCnt_d;
  logic [COUNT_WIDTH-1:0] freq_q,       freq_d;
  logic                   valid_q,      valid_d;
  logic                   overflow_q,   overflow_d;
  logic                   lost_q,       lost_d;

  logic                   windowEnd;
  logic                   edgeInc;
  logic                   edgeAtMax;
  logic [COUNT_WIDTH-1:0] countTotal;
  logic                   ovfTotal;
  logic [PROD_W-1:0]      product;
  logic                   mulSat;
  logic [COUNT_WIDTH-1:0] resultHz;
  logic [LOST_W-1:0]      lostNext;

  // The synchronized level is not needed here; only the edge pulse is counted.
  sync_edge_detect uSync (
    .clk       (clk),
    .rst       (rst),
    .async_in  (sig_in),
    .sync_out  (unusedSyncLevel),
    .rise_pulse(edgeDet)
  );

  // An edge arriving in the closing cycle still belongs to the closing window,
  // so the published total folds it in before the counter is cleared.
  assign windowEnd  = enable && (gateCnt_q == GATE_LAST);
  assign edgeInc    = edgeDet && enable;
  assign edgeAtMax  = (edgeCnt_q == COUNT_MAX);
  assign countTotal = (edgeInc && !edgeAtMax) ? edgeCnt_q + COUNT_WIDTH'(1) : edgeCnt_q;
  assign ovfTotal   = ovfPending_q || (edgeInc && edgeAtMax);
  assign product    = PROD_W'(countTotal) * GATE_MULT;
  assign mulSat     = |product[PROD_W-1:COUNT_WIDTH];
  assign resultHz   = mulSat ? COUNT_MAX : product[COUNT_WIDTH-1:0];
  assign lostNext   = (lostCnt_q == LOST_LIMIT) ? lostCnt_q : lostCnt_q + LOST_W'(1);

  // Next-state logic: advance the gate, accumulate edges and publish on window end.
  always_comb begin
    gateCnt_d    = gateCnt_q;
    edgeCnt_d    = edgeCnt_q;
    ovfPending_d = ovfPending_q;
    lostCnt_d    = lostCnt_q;
    freq_d       = freq_q;
    valid_d      = 1'b0;
    overflow_d   = overflow_q;
    lost_d       = lost_q;

    if (!enable) begin
      gateCnt_d    = '0;
      edgeCnt_d    = '0;
      ovfPending_d = 1'b0;
    end else if (windowEnd) begin
      gateCnt_d    = '0;
      edgeCnt_d    = '0;
      ovfPending_d = 1'b0;
      freq_d       = resultHz;
      overflow_d   = ovfTotal || mulSat;
      valid_d      = 1'b1;
      if (countTotal == '0) begin
        lostCnt_d = lostNext;
        lost_d    = (lostNext == LOST_LIMIT);
      end else begin
        lostCnt_d = '0;
        lost_d    = 1'b0;
      end
    end else begin
      gateCnt_d    = gateCnt_q + GATE_W'(1);
      edgeCnt_d    = countTotal;
      ovfPending_d = ovfTotal;
    end
  end

  // State register with synchronous clear of every counter and published result.
  always_ff @(posedge clk) begin
    if (rst) begin
      gateCnt_q    <= '0;
      edgeCnt_q    <= '0;
      ovfPending_q <= 1'b0;
      lostCnt_q    <= '0;
      freq_q       <= '0;
      valid_q      <= 1'b0;
      overflow_q   <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      gateCnt_q    <= gateCnt_d;
      edgeCnt_q    <= edgeCnt_d;
      ovfPending_q <= ovfPending_d;
      lostCnt_q    <= lostCnt_d;
      freq_q       <= freq_d;
      valid_q      <= valid_d;
      overflow_q   <= overflow_d;
      lost_q       <= lost_d;
    end
  end

  assign freq_hz     = freq_q;
  assign meas_valid  = valid_q;
  assign overflow    = overflow_q;
  assign signal_lost = lost_q;

endmodule
